mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
Multi-cycle controller for the MUL operation of the integer ALU (ALU_ctrl code 4'b0011). It accepts an issued ALU op and, when it is MUL, runs an iterative shift-add multiply over several cycles. While the multiply runs it holds a pipeline stall, then returns the low WIDTH bits of the product through a valid/ready handshake. It sits beside the single-cycle ALU in the execute stage; non-MUL codes are ignored and stay on the ALU path.

Parameters:
WIDTH, 32, operand and result width in bits
EARLY_EXIT, 1, when 1, iteration ends as soon as the remaining multiplier bits are all zero

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  execute stage presents an op
req_ready  out  1  sequencer can accept; high only in IDLE
alu_ctrl  in  4  decoded ALU control code; only 4'b0011 starts a multiply
op_a  in  WIDTH  multiplicand
op_b  in  WIDTH  multiplier
flush  in  1  kill any in-flight multiply
stall  out  1  hold pipeline; high in RUN and DONE
result_valid  out  1  product available; high only in DONE
result_ready  in  1  consumer takes result
result  out  WIDTH  low WIDTH bits of op_a*op_b

Behaviour:
- Reset (async, active-high): state=IDLE, req_ready=1, stall=0, result_valid=0, result=0, internal acc/mcand/mplier/count=0.
- States: IDLE, RUN, DONE.
- IDLE: req_ready=1. On req_valid && alu_ctrl==MUL && !flush: latch mcand=op_a, mplier=op_b, acc=0, count=0; next state RUN. A non-MUL code, or req_valid=0, leaves the state unchanged.
- RUN: one multiplier bit per cycle. If mplier[0], acc += mcand (mod 2^WIDTH). Then mcand <<= 1, mplier >>= 1, count++.
- RUN exit: go to DONE when count==WIDTH-1, or when EARLY_EXIT && (mplier>>1)==0. RUN always lasts at least 1 cycle.
- Latency, accept edge to result_valid high: WIDTH edges with EARLY_EXIT=0. With EARLY_EXIT=1: max(1, index of highest set bit of op_b + 1) edges.
- DONE: result_valid=1 and result=acc, both held stable until result_ready. On result_valid && result_ready, next state is IDLE and result_valid falls on that edge. A new request cannot be accepted on that same edge because req_ready is 0 in DONE.
- stall = (state != IDLE). It falls on the same edge the result is accepted.
- Arithmetic: unsigned shift-add. The low WIDTH bits equal the signed RV MUL result, so no sign handling is needed. Carries beyond WIDTH are discarded.
- flush: in RUN or DONE, next state is IDLE, result_valid=0, and the product is discarded. In IDLE, flush blocks acceptance that cycle. flush has priority over result_ready.
- Reset mid-RUN or mid-DONE: immediate return to IDLE with all outputs at reset values; no result is produced.
- alu_ctrl, op_a and op_b are don't-care outside the IDLE accept cycle.

Decomposition:
- Shared package alu_pkg: 4-bit ALU control constants (AND=0000, OR=0001, ADD=0010, MUL=0011, SLL=0100, SRL=0101, SUB=0110, XOR=0111) and the sequencer state enum. The ALU decoder and the ALU use the same constants.
- Sub-module mul_shift_add_dp: acc/mcand/mplier registers and the adder, controlled by load/step strobes. It outputs acc and mplier_next_zero. The FSM, counter and handshake stay in mul_sequencer.

Test Plan:
- EARLY_EXIT=0, op_a=7, op_b=6, MUL -> stall high for 32 cycles, result_valid after 32 edges, result=42, req_ready back high one edge after result_ready.
- EARLY_EXIT=1, op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> 32 edges, result=0x00000001. Same operands with op_b=0 -> 1 edge, result=0. op_b=6 -> 3 edges, result=6*op_a mod 2^32.
- Backpressure: result_ready=0 for 5 cycles in DONE -> result_valid and result held stable, stall held; accepted on the first result_ready=1.
- alu_ctrl=ADD (0010) with req_valid=1 in IDLE -> no state change, stall=0, result_valid never asserts.
- flush on the 10th RUN cycle of 100*3 -> IDLE next edge, result_valid never asserts; the next MUL 5*5 returns 25.
- Reset pulse mid-RUN, asynchronous and not clock-aligned -> outputs at reset values immediately. After release, MUL 12*12 returns 144.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: the 4-bit control codes used by the decoder,
// the single-cycle ALU and the multi-cycle multiply sequencer, plus the
// sequencer state encoding.
package alu_pkg;

    // ALU control codes produced by the decoder
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_MUL = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;

    // Multiply sequencer states
    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_t;

    // True for the one control code that is routed to the sequencer
    function automatic logic is_mul_op(input logic [3:0] ctrl);
        return (ctrl == ALU_MUL);
    endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath. Holds the accumulator, the left-shifting
// multiplicand and the right-shifting multiplier. i_load starts a new
// product, i_step retires one multiplier bit. All sequencing lives in the
// controller; this block only reacts to the two strobes.
module mul_shift_add_dp #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic [WIDTH-1:0] o_acc,
    output logic             o_mplier_next_zero
);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_acc_next;

    // Partial product for this step: the multiplicand gated by the current
    // low multiplier bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign w_addend[gi] = r_mcand[gi] & r_mplier[0];
        end
    endgenerate

    // Carries past WIDTH are dropped; only the low half of the product is kept.
    assign w_acc_next = r_acc + w_addend;

    // Load operands on accept, otherwise advance one bit per step
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= i_op_a;
            r_mplier <= i_op_b;
        end else if (i_step) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign o_acc = r_acc;

    // After the bit now being retired, nothing left to add: lets the
    // controller stop early once the multiplier is exhausted.
    assign o_mplier_next_zero = ~|r_mplier[WIDTH-1:1];

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle MUL controller beside the single-cycle ALU in execute.
// Accepts a MUL op in IDLE, iterates the shift-add datapath in RUN while
// stalling the pipeline, then offers the low WIDTH bits of the product in
// DONE through a valid/ready handshake. Other ALU codes are ignored.
module mul_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [3:0]       i_alu_ctrl,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_result_valid,
    input  logic             i_result_ready,
    output logic [WIDTH-1:0] o_result
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             w_load;
    logic             w_step;
    logic             w_run_last;
    logic [WIDTH-1:0] w_acc;
    logic             w_mplier_next_zero;

    mul_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_load             (w_load),
        .i_step             (w_step),
        .i_op_a             (i_op_a),
        .i_op_b             (i_op_b),
        .o_acc              (w_acc),
        .o_mplier_next_zero (w_mplier_next_zero)
    );

    // The bit being retired this cycle is the last one: either every bit
    // position has been visited, or (optionally) no set bits remain.
    assign w_run_last = (r_count == LAST_CNT) ||
                        (EARLY_EXIT && w_mplier_next_zero);

    // State and bit counter registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= SEQ_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // Next-state, datapath strobes and handshake outputs
    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_load         = 1'b0;
        w_step         = 1'b0;
        o_req_ready    = 1'b0;
        o_stall        = 1'b0;
        o_result_valid = 1'b0;
        o_result       = '0;

        case (r_state)
            SEQ_IDLE: begin
                o_req_ready = 1'b1;
                // flush in the accept cycle suppresses the start
                if (i_req_valid && is_mul_op(i_alu_ctrl) && !i_flush) begin
                    w_load       = 1'b1;
                    w_count_next = '0;
                    w_state_next = SEQ_RUN;
                end
            end

            SEQ_RUN: begin
                o_stall = 1'b1;
                if (i_flush) begin
                    w_state_next = SEQ_IDLE;
                end else begin
                    w_step       = 1'b1;
                    w_count_next = r_count + CNT_W'(1);
                    if (w_run_last) begin
                        w_state_next = SEQ_DONE;
                    end
                end
            end

            SEQ_DONE: begin
                o_stall        = 1'b1;
                o_result_valid = 1'b1;
                o_result       = w_acc;
                // flush and consumption both leave DONE; flush simply means
                // the product is dropped rather than delivered
                if (i_flush || i_result_ready) begin
                    w_state_next = SEQ_IDLE;
                end
            end

            default: begin
                w_state_next = SEQ_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed plus randomized bench for mul_sequencer. Two instances share the
// clock and reset: index 0 runs with EARLY_EXIT=0, index 1 with EARLY_EXIT=1.
// Expected products and latencies come from plain arithmetic on operands.
module tb_mul_sequencer;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid    [2];
    logic         req_ready    [2];
    logic [3:0]   alu_ctrl     [2];
    logic [W-1:0] op_a         [2];
    logic [W-1:0] op_b         [2];
    logic         flush        [2];
    logic         stall        [2];
    logic         result_valid [2];
    logic         result_ready [2];
    logic [W-1:0] result       [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mul_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (
        .i_clk(clk), .i_reset(reset),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .i_alu_ctrl(alu_ctrl[0]), .i_op_a(op_a[0]), .i_op_b(op_b[0]),
        .i_flush(flush[0]), .o_stall(stall[0]),
        .o_result_valid(result_valid[0]), .i_result_ready(result_ready[0]),
        .o_result(result[0])
    );

    mul_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (
        .i_clk(clk), .i_reset(reset),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .i_alu_ctrl(alu_ctrl[1]), .i_op_a(op_a[1]), .i_op_b(op_b[1]),
        .i_flush(flush[1]), .o_stall(stall[1]),
        .o_result_valid(result_valid[1]), .i_result_ready(result_ready[1]),
        .o_result(result[1])
    );

    // Reference: low W bits of the full unsigned product
    function automatic logic [W-1:0] model_product(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return p[W-1:0];
    endfunction

    // Reference: edges from accept to result_valid
    function automatic int model_latency(input int sel, input logic [W-1:0] b);
        int hi;
        hi = -1;
        if (sel == 0) return W;
        for (int i = 0; i < W; i++) if (b[i]) hi = i;
        return (hi + 1 < 1) ? 1 : hi + 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int sel, input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready[sel]), 64'd1);
        chk({tag, "_stall"}, 64'(stall[sel]), 64'd0);
        chk({tag, "_result_valid"}, 64'(result_valid[sel]), 64'd0);
        chk({tag, "_result"}, 64'(result[sel]), 64'd0);
    endtask

    // One full multiply on instance sel, entered and left at a negedge.
    // hold = cycles of result_ready=0 in DONE before consuming.
    task automatic do_mul(input int sel, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [W-1:0] exp_p;
        logic [W-1:0] held;
        int exp_l;
        int n;
        int stall_drops;
        exp_p = model_product(a, b);
        exp_l = model_latency(sel, b);
        chk("req_ready_pre", 64'(req_ready[sel]), 64'd1);
        req_valid[sel] = 1'b1;
        alu_ctrl[sel]  = ALU_MUL;
        op_a[sel]      = a;
        op_b[sel]      = b;
        @(posedge clk);
        @(negedge clk);
        req_valid[sel] = 1'b0;
        alu_ctrl[sel]  = 4'($urandom);
        op_a[sel]      = $urandom;
        op_b[sel]      = $urandom;
        chk("stall_run", 64'(stall[sel]), 64'd1);
        chk("req_ready_run", 64'(req_ready[sel]), 64'd0);
        n = 0;
        stall_drops = 0;
        while (!result_valid[sel] && n < W + 4) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!stall[sel]) stall_drops++;
        end
        chk("latency", 64'(n), 64'(exp_l));
        chk("stall_held", 64'(stall_drops), 64'd0);
        chk("result", 64'(result[sel]), 64'(exp_p));
        held = result[sel];
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_valid", 64'(result_valid[sel]), 64'd1);
            chk("bp_result", 64'(result[sel]), 64'(held));
            chk("bp_stall", 64'(stall[sel]), 64'd1);
        end
        result_ready[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready[sel] = 1'b0;
        chk("post_valid", 64'(result_valid[sel]), 64'd0);
        chk("post_stall", 64'(stall[sel]), 64'd0);
        chk("post_req_ready", 64'(req_ready[sel]), 64'd1);
        $display("[TB] mul dut%0d a=%08h b=%08h -> %08h lat=%0d (exp %08h lat=%0d)",
                 sel, a, b, held, n, exp_p, exp_l);
    endtask

    initial begin
        logic [3:0] non_mul [7];
        int seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        non_mul = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SRL, ALU_SUB, ALU_XOR};
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0; alu_ctrl[s] = ALU_ADD; op_a[s] = '0; op_b[s] = '0;
            flush[s] = 1'b0; result_ready[s] = 1'b0;
        end
        #1;
        chk_idle(0, "rst0");
        chk_idle(1, "rst1");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_idle(0, "idle0");
        chk_idle(1, "idle1");

        // Directed products
        do_mul(0, 32'd7, 32'd6, 0);
        do_mul(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_mul(1, 32'hFFFF_FFFF, 32'd0, 0);
        do_mul(1, 32'hFFFF_FFFF, 32'd6, 5);
        do_mul(1, 32'h1234_5678, 32'd1, 1);
        do_mul(0, 32'h8000_0000, 32'h8000_0000, 2);

        // Non-MUL codes leave the sequencer idle
        for (int i = 0; i < 7; i++) begin
            req_valid[1] = 1'b1;
            alu_ctrl[1]  = non_mul[i];
            op_a[1]      = $urandom;
            op_b[1]      = $urandom;
            @(posedge clk);
            @(negedge clk);
            chk("nonmul_stall", 64'(stall[1]), 64'd0);
            chk("nonmul_valid", 64'(result_valid[1]), 64'd0);
            $display("[TB] non-mul code %04b dut1 stall=%0d valid=%0d", non_mul[i], stall[1], result_valid[1]);
        end
        req_valid[1] = 1'b0;

        // flush in IDLE blocks acceptance
        req_valid[1] = 1'b1; alu_ctrl[1] = ALU_MUL; op_a[1] = 32'd9; op_b[1] = 32'd9;
        flush[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0; flush[1] = 1'b0;
        chk("flush_idle_stall", 64'(stall[1]), 64'd0);
        chk("flush_idle_ready", 64'(req_ready[1]), 64'd1);
        $display("[TB] flush-in-idle dut1 stall=%0d", stall[1]);

        // flush on the 10th RUN cycle of 100*3
        req_valid[0] = 1'b1; alu_ctrl[0] = ALU_MUL; op_a[0] = 32'd100; op_b[0] = 32'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("flush_run_stall", 64'(stall[0]), 64'd1);
        flush[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush[0] = 1'b0;
        chk("flush_run_stall_after", 64'(stall[0]), 64'd0);
        chk("flush_run_ready_after", 64'(req_ready[0]), 64'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (result_valid[0]) seen++;
        end
        chk("flush_run_no_valid", 64'(seen), 64'd0);
        $display("[TB] flush-in-run dut0 valid_seen=%0d", seen);
        do_mul(0, 32'd5, 32'd5, 0);

        // flush in DONE discards the product
        req_valid[1] = 1'b1; alu_ctrl[1] = ALU_MUL; op_a[1] = 32'd3; op_b[1] = 32'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("flush_done_valid_before", 64'(result_valid[1]), 64'd1);
        flush[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush[1] = 1'b0;
        chk("flush_done_valid_after", 64'(result_valid[1]), 64'd0);
        chk("flush_done_stall_after", 64'(stall[1]), 64'd0);
        $display("[TB] flush-in-done dut1 valid=%0d stall=%0d", result_valid[1], stall[1]);

        // Randomized products on both instances
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            do_mul(i % 2, ra, rb, $urandom_range(0, 3));
        end

        // Asynchronous reset mid-RUN
        req_valid[1] = 1'b1; alu_ctrl[1] = ALU_MUL; op_a[1] = $urandom; op_b[1] = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("rst_mid_stall_before", 64'(stall[1]), 64'd1);
        #3;
        reset = 1'b1;
        #1;
        chk_idle(1, "rst_mid");
        $display("[TB] async reset mid-run dut1 stall=%0d ready=%0d", stall[1], req_ready[1]);
        #7;
        reset = 1'b0;
        @(negedge clk);
        chk_idle(1, "rst_mid_rel");
        do_mul(1, 32'd12, 32'd12, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
